// File: rtl/fifo_read_ctrl_if.sv
// Consumer-side valid/ready stream carrying words out of the FIFO read controller.
interface fifo_read_ctrl_if #(
   parameter int DATA_SIZE = 8
);
   logic [DATA_SIZE-1:0] dout;
   logic                 dout_valid;
   logic                 dout_ready;

   modport master (output dout, output dout_valid, input dout_ready);
   modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/fifo_read_ctrl.sv
// FIFO read-side controller: Gray/binary read pointer, registered empty, 2-entry output buffer.
// Optional almost-empty flag and AE_LEVEL parameter exist only when RD_ALMOST_EMPTY_EN is defined.
module fifo_read_ctrl #(
   parameter int DATA_SIZE = 8,
   parameter int ADDR_SIZE = 4
`ifdef RD_ALMOST_EMPTY_EN
   , parameter int AE_LEVEL = 2
`endif
) (
   input  logic                 rclk,
   input  logic                 rrst,
   input  logic [ADDR_SIZE:0]   rq2_wptr,
   output logic [ADDR_SIZE:0]   rptr,
   output logic [ADDR_SIZE-1:0] raddr,
   output logic                 rinc,
   output logic                 rempty,
   input  logic [DATA_SIZE-1:0] rdata_mem,
   fifo_read_ctrl_if.master     stream,
   output logic [ADDR_SIZE:0]   rlevel
`ifdef RD_ALMOST_EMPTY_EN
   , output logic               almost_empty
`endif
);

   function automatic logic [ADDR_SIZE:0] gray2bin(input logic [ADDR_SIZE:0] g);
      logic [ADDR_SIZE:0] b;
      b[ADDR_SIZE] = g[ADDR_SIZE];
      for (int i = ADDR_SIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   logic [ADDR_SIZE:0]   rbin;
   logic [ADDR_SIZE:0]   rbinnext;
   logic [ADDR_SIZE:0]   rgraynext;
   logic [ADDR_SIZE:0]   level_next;
   logic                 in_flight;
   logic [1:0]           buf_count;
   logic [DATA_SIZE-1:0] head;
   logic [DATA_SIZE-1:0] skid;
   logic                 pop;
   logic [2:0]           occ_next;

   assign pop               = stream.dout_valid && stream.dout_ready;
   assign stream.dout       = head;
   assign stream.dout_valid = (buf_count != 2'd0);
   assign raddr             = rbin[ADDR_SIZE-1:0];

   // Occupancy after this edge (buffered + in-flight, minus the word leaving) must stay
   // below 2 before another read is issued, so the buffer can never overflow.
   // NOTE: every always_comb output gets a default on entry so no latch can be inferred.
   always_comb begin
      occ_next   = 3'd0;
      rinc       = 1'b0;
      occ_next   = {1'b0, buf_count} + {2'b0, in_flight} - {2'b0, pop};
      rinc       = !rrst && !rempty && (occ_next < 3'd2);
      rbinnext   = rbin + {{ADDR_SIZE{1'b0}}, rinc};
      rgraynext  = (rbinnext >> 1) ^ rbinnext;
      level_next = gray2bin(rq2_wptr) - rbinnext;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge rclk) begin
      if (rrst) begin
         rbin      <= '0;
         rptr      <= '0;
         rempty    <= 1'b1;
         in_flight <= 1'b0;
         rlevel    <= '0;
      end else begin
         rbin      <= rbinnext;
         rptr      <= rgraynext;
         rempty    <= (rgraynext == rq2_wptr);
         in_flight <= rinc;
         rlevel    <= level_next;
      end
   end

   // Word returned by the memory lands at the tail; a simultaneous pop shifts skid to head.
   always_ff @(posedge rclk) begin
      if (rrst) begin
         head      <= '0;
         skid      <= '0;
         buf_count <= 2'd0;
      end else begin
         case ({in_flight, pop})
            2'b10: begin
               if (buf_count == 2'd0) head <= rdata_mem;
               else                   skid <= rdata_mem;
               buf_count <= buf_count + 2'd1;
            end
            2'b01: begin
               head      <= skid;
               buf_count <= buf_count - 2'd1;
            end
            2'b11: begin
               if (buf_count == 2'd1) begin
                  head <= rdata_mem;
               end else begin
                  head <= skid;
                  skid <= rdata_mem;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef RD_ALMOST_EMPTY_EN
   localparam logic [ADDR_SIZE:0] AE_THRESH = (ADDR_SIZE + 1)'(AE_LEVEL);

   always_ff @(posedge rclk) begin
      if (rrst) almost_empty <= 1'b1;
      else      almost_empty <= (level_next <= AE_THRESH);
   end
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Scoreboard bench for fifo_read_ctrl: behavioural memory, driven write pointer, output monitor.
module tb_fifo_read_ctrl;
   localparam int DW = 8;
   localparam int AW = 4;

   logic          rclk = 1'b0;
   logic          rrst = 1'b1;
   logic [AW:0]   rq2_wptr = '0;
   logic [AW:0]   rptr;
   logic [AW-1:0] raddr;
   logic          rinc;
   logic          rempty;
   logic [DW-1:0] rdata_mem = '0;
   logic [AW:0]   rlevel;
`ifdef RD_ALMOST_EMPTY_EN
   logic          almost_empty;
`endif

   fifo_read_ctrl_if #(.DATA_SIZE(DW)) stream_if ();

   fifo_read_ctrl #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (
      .rclk      (rclk),
      .rrst      (rrst),
      .rq2_wptr  (rq2_wptr),
      .rptr      (rptr),
      .raddr     (raddr),
      .rinc      (rinc),
      .rempty    (rempty),
      .rdata_mem (rdata_mem),
      .stream    (stream_if),
      .rlevel    (rlevel)
`ifdef RD_ALMOST_EMPTY_EN
      , .almost_empty (almost_empty)
`endif
   );

   always #5 rclk = ~rclk;

   // Memory with registered 1-cycle read
   logic [DW-1:0] mem [0:15];
   always @(posedge rclk) if (rinc) rdata_mem <= mem[raddr];

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [DW-1:0] exp_q[$];
   logic [AW:0]   wbin = '0;
   int            rinc_cnt = 0;
   int            valid_run = 0;
   int            max_run = 0;
   logic          seen_wrap = 1'b0;
   logic [AW:0]   prev_rptr = '0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: pops the scoreboard on each accepted word and tracks pointer/handshake activity
   always @(negedge rclk) begin
      if (rrst === 1'b0) begin
         if (rinc) rinc_cnt++;
         if (stream_if.dout_valid) begin
            valid_run++;
            if (valid_run > max_run) max_run = valid_run;
         end else begin
            valid_run = 0;
         end
         if (prev_rptr == 5'b10000 && rptr == 5'b00000) seen_wrap = 1'b1;
         prev_rptr = rptr;
         if (stream_if.dout_valid && stream_if.dout_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL dout_unexpected: got 0x%0h, want no word", stream_if.dout);
            end else begin
               logic [DW-1:0] e;
               e = exp_q.pop_front();
               check("dout", 32'(stream_if.dout), 32'(e));
            end
         end
      end
   end

   task automatic tick();
      @(posedge rclk);
      #1;
   endtask

   task automatic next_sample();
      @(posedge rclk);
      @(negedge rclk);
   endtask

   task automatic do_reset();
      rrst     = 1'b1;
      rq2_wptr = 5'b00011;
      stream_if.dout_ready = 1'b0;
      exp_q.delete();
      wbin = '0;
      tick();
      tick();
      rq2_wptr = '0;
      rrst     = 1'b0;
   endtask

   task automatic write_words(input int n, input logic [DW-1:0] base);
      for (int i = 0; i < n; i++) begin
         mem[wbin[AW-1:0]] = base + DW'(i);
         exp_q.push_back(base + DW'(i));
         wbin = wbin + 1'b1;
      end
      rq2_wptr = wbin ^ (wbin >> 1);
   endtask

   task automatic drain(input int budget, input bit throttle);
      int cyc = 0;
      while (exp_q.size() != 0 && cyc < budget) begin
         stream_if.dout_ready = throttle ? (cyc % 3 != 0) : 1'b1;
         tick();
         cyc++;
      end
      stream_if.dout_ready = 1'b1;
      check("drain_left", 32'(exp_q.size()), 32'd0);
      repeat (3) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, want finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset held two edges with a non-zero write pointer present
      rrst = 1'b1;
      rq2_wptr = 5'b00011;
      stream_if.dout_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         next_sample();
         check("rst_rempty", 32'(rempty), 32'd1);
         check("rst_rptr", 32'(rptr), 32'd0);
         check("rst_rinc", 32'(rinc), 32'd0);
         check("rst_valid", 32'(stream_if.dout_valid), 32'd0);
         check("rst_rlevel", 32'(rlevel), 32'd0);
         check("rst_dout", 32'(stream_if.dout), 32'd0);
`ifdef RD_ALMOST_EMPTY_EN
         check("rst_ae", 32'(almost_empty), 32'd1);
`endif
      end
      tick();
      rq2_wptr = '0;
      rrst = 1'b0;

      // Single word
      stream_if.dout_ready = 1'b1;
      rinc_cnt = 0;
      write_words(1, 8'hA5);
      next_sample();
      check("sw_rempty_low", 32'(rempty), 32'd0);
      check("sw_rinc", 32'(rinc), 32'd1);
      check("sw_raddr", 32'(raddr), 32'd0);
      next_sample();
      check("sw_rptr", 32'(rptr), 32'd1);
      check("sw_rempty_back", 32'(rempty), 32'd1);
      check("sw_rinc_off", 32'(rinc), 32'd0);
      check("sw_valid_early", 32'(stream_if.dout_valid), 32'd0);
      next_sample();
      check("sw_valid", 32'(stream_if.dout_valid), 32'd1);
      check("sw_dout", 32'(stream_if.dout), 32'hA5);
      next_sample();
      check("sw_valid_off", 32'(stream_if.dout_valid), 32'd0);
      repeat (3) next_sample();
      check("sw_rinc_cnt", 32'(rinc_cnt), 32'd1);
      tick();

      // Full burst of 16 words through a 16-deep memory
      do_reset();
      stream_if.dout_ready = 1'b1;
      rinc_cnt = 0;
      max_run = 0;
      valid_run = 0;
      write_words(16, 8'h00);
      drain(80, 1'b0);
      check("burst_run", 32'(max_run), 32'd16);
      check("burst_rinc_cnt", 32'(rinc_cnt), 32'd16);
      check("burst_rptr", 32'(rptr), 32'b11000);
      check("burst_raddr", 32'(raddr), 32'd0);
      check("burst_rempty", 32'(rempty), 32'd1);
      check("burst_rlevel", 32'(rlevel), 32'd0);

      // Backpressure: only two words pulled from memory while stalled
      do_reset();
      stream_if.dout_ready = 1'b0;
      rinc_cnt = 0;
      write_words(5, 8'h10);
      repeat (8) next_sample();
      check("bp_rinc_cnt", 32'(rinc_cnt), 32'd2);
      check("bp_valid", 32'(stream_if.dout_valid), 32'd1);
      check("bp_dout", 32'(stream_if.dout), 32'h10);
      check("bp_rlevel", 32'(rlevel), 32'd3);
      repeat (2) next_sample();
      check("bp_dout_hold", 32'(stream_if.dout), 32'h10);
      check("bp_rinc_hold", 32'(rinc_cnt), 32'd2);
      tick();
      drain(40, 1'b0);
      check("bp_rinc_total", 32'(rinc_cnt), 32'd5);

      // Pointer wrap: 40 words in chunks with a throttled consumer
      do_reset();
      rinc_cnt = 0;
      seen_wrap = 1'b0;
      for (int c = 0; c < 4; c++) begin
         write_words(10, 8'(8'h40 + c * 10));
         drain(100, 1'b1);
      end
      check("wrap_seen", 32'(seen_wrap), 32'd1);
      check("wrap_rinc_cnt", 32'(rinc_cnt), 32'd40);
      check("wrap_rptr", 32'(rptr), 32'b01100);
      check("wrap_rlevel", 32'(rlevel), 32'd0);

      // Level countdown under stall: 4 -> 3 -> 2, almost-empty asserts at 2
      do_reset();
      stream_if.dout_ready = 1'b0;
      write_words(4, 8'h80);
      next_sample();
      check("lvl_4", 32'(rlevel), 32'd4);
`ifdef RD_ALMOST_EMPTY_EN
      check("ae_at_4", 32'(almost_empty), 32'd0);
`endif
      next_sample();
      check("lvl_3", 32'(rlevel), 32'd3);
`ifdef RD_ALMOST_EMPTY_EN
      check("ae_at_3", 32'(almost_empty), 32'd0);
`endif
      next_sample();
      check("lvl_2", 32'(rlevel), 32'd2);
`ifdef RD_ALMOST_EMPTY_EN
      check("ae_at_2", 32'(almost_empty), 32'd1);
`endif
      next_sample();
      check("lvl_hold", 32'(rlevel), 32'd2);
      tick();
      drain(40, 1'b0);

      check("final_queue", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
